// File: rtl/somador_pkg.sv
// rtl/somador_pkg.sv - shared width constant, operand type and flag helpers for somador4bits
package somador_pkg;

    localparam int SOMA_WIDTH = 4;

    typedef logic [SOMA_WIDTH-1:0] soma_t;

    // Signed overflow: both operands share a sign that the sum does not.
    function automatic logic soma_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell used by the ripple-carry chain
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = x ^ y;
    assign s  = p ^ ci;
    assign co = (x & y) | (ci & p);

endmodule

// File: rtl/somador4bits.sv
// rtl/somador4bits.sv - registered ripple-carry adder with carry, overflow and zero flags
module somador4bits
    import somador_pkg::*;
#(
    parameter int WIDTH = SOMA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] saida,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;
    logic             sum_ovf;
    logic             sum_zero;

    logic [WIDTH-1:0] saida_q, saida_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    assign carry[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_fa
            full_adder u_fa (
                .x  (a[i]),
                .y  (b[i]),
                .ci (carry[i]),
                .s  (sum[i]),
                .co (carry[i+1])
            );
        end
    endgenerate

    assign sum_ovf  = soma_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
    assign sum_zero = (sum == '0);

    // Operands are only looked at under in_valid, so junk on a/b while idle never reaches state.
    always_comb begin
        saida_d = saida_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        valid_d = 1'b0;
        if (in_valid) begin
            saida_d = sum;
            cout_d  = carry[WIDTH];
            ovf_d   = sum_ovf;
            zero_d  = sum_zero;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            saida_q <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            saida_q <= saida_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    assign saida     = saida_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_somador4bits.sv
// tb/tb_somador4bits.sv - directed-vector self-checking bench for somador4bits
module tb_somador4bits;
    import somador_pkg::*;

    logic  clk;
    logic  rst_n;
    logic  in_valid;
    soma_t a;
    soma_t b;
    soma_t saida;
    logic  cout;
    logic  ovf;
    logic  zero;
    logic  out_valid;

    int n_cmp;
    int n_bad;

    somador4bits #(.WIDTH(SOMA_WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .saida     (saida),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] s, input logic c,
                           input logic o, input logic z, input logic v);
        chk({tag, ".saida"},     32'(saida),     32'(s));
        chk({tag, ".cout"},      32'(cout),      32'(c));
        chk({tag, ".ovf"},       32'(ovf),       32'(o));
        chk({tag, ".zero"},      32'(zero),      32'(z));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv);
        in_valid = v;
        a        = av;
        b        = bv;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        @(negedge clk);
        step();
        step();
        chk_out("reset", 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);

        rst_n = 1'b1;
        drive(1'b1, 4'h6, 4'h1); step();
        chk_out("6+1", 4'h7, 1'b0, 1'b0, 1'b0, 1'b1);

        drive(1'b1, 4'h0, 4'h7); step();
        chk_out("seq0+7", 4'h7, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'h6, 4'h1); step();
        chk_out("seq6+1", 4'h7, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'h1, 4'h1); step();
        chk_out("seq1+1", 4'h2, 1'b0, 1'b0, 1'b0, 1'b1);

        drive(1'b1, 4'hF, 4'h1); step();
        chk_out("F+1", 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 4'h7, 4'h1); step();
        chk_out("7+1", 4'h8, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 4'h8, 4'h8); step();
        chk_out("8+8", 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 4'h8, 4'hF); step();
        chk_out("8+F", 4'h7, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 4'hC, 4'h5); step();
        chk_out("C+5", 4'h1, 1'b1, 1'b0, 1'b0, 1'b1);

        drive(1'b1, 4'h3, 4'h4); step();
        chk_out("3+4", 4'h7, 1'b0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        a = 'x;
        b = 'x;
        step();
        chk_out("hold1", 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'hF, 4'hF); step();
        chk_out("hold2", 4'h7, 1'b0, 1'b0, 1'b0, 1'b0);

        drive(1'b1, 4'h9, 4'h9); step();
        chk_out("9+9", 4'h2, 1'b1, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        drive(1'b1, 4'h5, 4'h5); step();
        chk_out("rst_prio", 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        drive(1'b1, 4'h2, 4'h3); step();
        chk_out("post_rst", 4'h5, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 4'h0, 4'h0); step();
        chk_out("post_idle", 4'h5, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
